// File: rtl/display_page_sequencer_if.sv
// display_page_sequencer_if: page inputs, mode controls and Hex output bus of the page sequencer.
interface display_page_sequencer_if #(
  parameter int NUM_DIGITS = 6,
  parameter int NUM_PAGES  = 8,
  parameter int PAGE_W     = 3,
  parameter int SEG_W      = 7
) ();
  logic                                  Tick;
  logic [NUM_PAGES*NUM_DIGITS*SEG_W-1:0] PageData;
  logic [NUM_PAGES-1:0]                  PageEnable;
  logic                                  ModeAuto;
  logic [PAGE_W-1:0]                     ManualPage;
  logic                                  Next;
  logic                                  Alert;
  logic [NUM_DIGITS*SEG_W-1:0]           Hex;
  logic [PAGE_W-1:0]                     CurrentPage;
  logic                                  PageChanged;
  modport master (
    output Tick, PageData, PageEnable, ModeAuto, ManualPage, Next, Alert,
    input  Hex, CurrentPage, PageChanged
  );
  modport slave (
    input  Tick, PageData, PageEnable, ModeAuto, ManualPage, Next, Alert,
    output Hex, CurrentPage, PageChanged
  );
endinterface

// File: rtl/display_page_sequencer.sv
// display_page_sequencer: picks one pre-rendered seven-segment page, manually or by timed
// rotation over enabled pages, with alert blinking and a registered Hex output.
module display_page_sequencer #(
  parameter int NUM_DIGITS  = 6,
  parameter int NUM_PAGES   = 8,
  parameter int PAGE_W      = 3,
  parameter int SEG_W       = 7,
  parameter int DWELL_TICKS = 200,
  parameter int BLINK_TICKS = 50
) (
  input logic Clock,
  input logic Reset,
  display_page_sequencer_if.slave bus
);
  localparam int HEX_W = NUM_DIGITS * SEG_W;
  localparam int DW = DWELL_TICKS > 1 ? $clog2(DWELL_TICKS) : 1;
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  typedef enum logic {MANUAL, AUTO} state_t;
  state_t            state_q, state_d;
  logic [PAGE_W-1:0] page_q, page_d, nxt;
  logic              changed_q, changed_d;
  logic [HEX_W-1:0]  hex_q, hex_d, sel;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [BW-1:0]     blink_q, blink_d;
  logic              phase_q, phase_d;
  logic              adv, wrap, valid, en_cur;
  int                idx;
  always_comb begin
    state_d = bus.ModeAuto ? AUTO : MANUAL;
    adv = bus.Next || (bus.Tick && dwell_q == DW'(DWELL_TICKS - 1));
    // Descending scan so the nearest enabled successor wins; offset NUM_PAGES is the current page.
    idx = 0;
    nxt = page_q;
    for (int k = NUM_PAGES; k >= 1; k--) begin
      idx = (int'(page_q) + k) % NUM_PAGES;
      if (1'(bus.PageEnable >> idx)) nxt = PAGE_W'(idx);
    end
    page_d = page_q;
    dwell_d = '0;
    if (state_q == MANUAL && !bus.ModeAuto) page_d = bus.ManualPage;
    else if (state_q == AUTO && bus.ModeAuto) begin
      page_d = adv ? nxt : page_q;
      dwell_d = adv ? '0 : bus.Tick ? dwell_q + DW'(1) : dwell_q;
    end
    changed_d = page_d != page_q;
    wrap = bus.Tick && blink_q == BW'(BLINK_TICKS - 1);
    blink_d = !bus.Alert ? '0 : !bus.Tick ? blink_q : wrap ? '0 : blink_q + BW'(1);
    phase_d = !bus.Alert || (phase_q ^ wrap);
    valid = int'(page_q) < NUM_PAGES;
    en_cur = 1'(bus.PageEnable >> page_q);
    sel = HEX_W'(bus.PageData >> (int'(page_q) * HEX_W));
    hex_d = (valid && phase_q && (state_q == MANUAL || en_cur)) ? sel : '1;
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= MANUAL;
      page_q    <= '0;
      changed_q <= 1'b0;
      hex_q     <= '1;
      dwell_q   <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      changed_q <= changed_d;
      hex_q     <= hex_d;
      dwell_q   <= dwell_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
    end
  end
  assign bus.Hex         = hex_q;
  assign bus.CurrentPage = page_q;
  assign bus.PageChanged = changed_q;
endmodule

// File: tb/tb_display_page_sequencer.sv
// tb_display_page_sequencer: directed vectors and hand-written rotation/blink/reset sequences.
module tb_display_page_sequencer;
  localparam int ND = 6, NP = 8, PW = 4, SW = 7, HW = ND * SW;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int tests = 0, fails = 0;
  logic [NP*HW-1:0] pd;
  logic [HW-1:0] blank = '1;
  display_page_sequencer_if #(.NUM_DIGITS(ND), .NUM_PAGES(NP), .PAGE_W(PW), .SEG_W(SW)) bus ();
  display_page_sequencer #(.NUM_DIGITS(ND), .NUM_PAGES(NP), .PAGE_W(PW), .SEG_W(SW),
                           .DWELL_TICKS(4), .BLINK_TICKS(2)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus));
  always #5 Clock = ~Clock;
  typedef struct {
    logic [PW-1:0] mp;
    logic          chg;
    logic          blk;
  } vec_t;
  vec_t vecs[8];
  function automatic logic [HW-1:0] pg(int p);
    return pd[p*HW +: HW];
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask
  task automatic run_ticks(int n, output int changes);
    changes = 0;
    for (int i = 0; i < n; i++) begin
      bus.Tick = 1'b1;
      step(1);
      changes += int'(bus.PageChanged);
      bus.Tick = 1'b0;
      step(1);
      changes += int'(bus.PageChanged);
      step(1);
      changes += int'(bus.PageChanged);
    end
  endtask
  int ch;
  int seq[3] = '{2, 5, 0};
  initial begin
    for (int p = 0; p < NP; p++)
      for (int d = 0; d < ND; d++) pd[(p*ND+d)*SW +: SW] = SW'(p*17 + d*9 + 3);
    pd[3*HW +: HW] = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    bus.PageData = pd;
    bus.Tick = 0; bus.Next = 0; bus.Alert = 0; bus.ModeAuto = 0;
    bus.ManualPage = 4'd3; bus.PageEnable = '0;
    vecs[0] = '{4'd5, 1'b1, 1'b0};
    vecs[1] = '{4'd5, 1'b0, 1'b0};
    vecs[2] = '{4'd9, 1'b1, 1'b1};
    vecs[3] = '{4'd0, 1'b1, 1'b0};
    vecs[4] = '{4'd7, 1'b1, 1'b0};
    vecs[5] = '{4'd8, 1'b1, 1'b1};
    vecs[6] = '{4'd3, 1'b1, 1'b0};
    vecs[7] = '{4'd3, 1'b0, 1'b0};
    step(2);
    chk("reset_hex", 64'(bus.Hex), 64'(blank));
    chk("reset_page", 64'(bus.CurrentPage), 0);
    chk("reset_chg", 64'(bus.PageChanged), 0);
    Reset = 1'b1;
    step(1);
    chk("rel_page", 64'(bus.CurrentPage), 3);
    chk("rel_chg", 64'(bus.PageChanged), 1);
    step(1);
    chk("rel_chg_once", 64'(bus.PageChanged), 0);
    chk("rel_hex", 64'(bus.Hex), 64'(pg(3)));
    foreach (vecs[i]) begin
      bus.ManualPage = vecs[i].mp;
      step(1);
      chk($sformatf("man%0d_page", i), 64'(bus.CurrentPage), 64'(vecs[i].mp));
      chk($sformatf("man%0d_chg", i), 64'(bus.PageChanged), 64'(vecs[i].chg));
      step(1);
      chk($sformatf("man%0d_hex", i), 64'(bus.Hex), vecs[i].blk ? 64'(blank) : 64'(pg(int'(vecs[i].mp))));
    end
    bus.ManualPage = 4'd0;
    step(2);
    bus.PageEnable = 8'b0010_0101;
    bus.ModeAuto = 1'b1;
    bus.ManualPage = 4'd6;
    step(1);
    chk("auto_entry_page", 64'(bus.CurrentPage), 0);
    foreach (seq[i]) begin
      run_ticks(3, ch);
      chk($sformatf("rot%0d_hold", i), 64'(ch), 0);
      run_ticks(1, ch);
      chk($sformatf("rot%0d_page", i), 64'(bus.CurrentPage), 64'(seq[i]));
      chk($sformatf("rot%0d_chg", i), 64'(ch), 1);
      chk($sformatf("rot%0d_hex", i), 64'(bus.Hex), 64'(pg(seq[i])));
    end
    run_ticks(4, ch);
    chk("nx_pre_page", 64'(bus.CurrentPage), 2);
    run_ticks(3, ch);
    bus.Tick = 1'b1; bus.Next = 1'b1;
    step(1);
    chk("nx_tick_page", 64'(bus.CurrentPage), 5);
    chk("nx_tick_chg", 64'(bus.PageChanged), 1);
    bus.Tick = 1'b0; bus.Next = 1'b0;
    step(1);
    chk("nx_tick_single", 64'(bus.CurrentPage), 5);
    chk("nx_tick_chg_end", 64'(bus.PageChanged), 0);
    run_ticks(3, ch);
    chk("nx_dwell_restart", 64'(ch), 0);
    run_ticks(1, ch);
    chk("nx_dwell_expire", 64'(bus.CurrentPage), 0);
    bus.Next = 1'b1;
    step(1);
    bus.Next = 1'b0;
    chk("next_only", 64'(bus.CurrentPage), 2);
    bus.PageEnable = '0;
    step(2);
    chk("none_hex", 64'(bus.Hex), 64'(blank));
    run_ticks(4, ch);
    chk("none_page", 64'(bus.CurrentPage), 2);
    chk("none_chg", 64'(ch), 0);
    chk("none_hex2", 64'(bus.Hex), 64'(blank));
    bus.PageEnable = 8'b1000_0000;
    run_ticks(4, ch);
    chk("only7_page", 64'(bus.CurrentPage), 7);
    chk("only7_chg", 64'(ch), 1);
    chk("only7_hex", 64'(bus.Hex), 64'(pg(7)));
    run_ticks(4, ch);
    chk("self_page", 64'(bus.CurrentPage), 7);
    chk("self_chg", 64'(ch), 0);
    bus.Alert = 1'b1;
    run_ticks(2, ch);
    chk("blink_off1", 64'(bus.Hex), 64'(blank));
    run_ticks(2, ch);
    chk("blink_on", 64'(bus.Hex), 64'(pg(7)));
    run_ticks(2, ch);
    chk("blink_off2", 64'(bus.Hex), 64'(blank));
    chk("blink_page", 64'(bus.CurrentPage), 7);
    bus.Alert = 1'b0;
    step(2);
    chk("alert_drop", 64'(bus.Hex), 64'(pg(7)));
    bus.PageEnable = 8'b0010_0101;
    for (int i = 0; i < 3; i++) begin
      bus.Next = 1'b1;
      step(1);
    end
    bus.Next = 1'b0;
    chk("pre_rst_page", 64'(bus.CurrentPage), 5);
    bus.Alert = 1'b1;
    step(2);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_hex", 64'(bus.Hex), 64'(blank));
    chk("arst_page", 64'(bus.CurrentPage), 0);
    chk("arst_chg", 64'(bus.PageChanged), 0);
    step(2);
    Reset = 1'b1;
    step(1);
    chk("post_rst_page", 64'(bus.CurrentPage), 0);
    run_ticks(3, ch);
    chk("post_rst_hold", 64'(ch), 0);
    run_ticks(1, ch);
    chk("post_rst_adv", 64'(bus.CurrentPage), 2);
    chk("post_rst_chg", 64'(ch), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
